block_hash: RTL and testbench
=============================

# block_hash

Parametrised successor to the fixed-output `encrypt` stub: a multi-word hash engine. It accepts a message as a stream of `DATA_W`-bit words under a valid/ready handshake and buffers them into blocks of `BLOCK_WORDS`. It compresses each block into a running accumulator with a four-operation round schedule (add/xor/sub/xnor), then folds in the message length. It keeps the `start`/`finished`/`hash` contract of the hashing datapath, adds message framing and abort, and is the drop-in core behind the SHA module's top level.

## Interface

- `DATA_W`, 32: word, accumulator and hash width (≥8).
- `BLOCK_WORDS`, 4: words per block (power of two, 2..16).
- `IV`, 32'h0123_4567: accumulator initial value, zero-extended or truncated to `DATA_W`.
- `ROT`, 5: left-rotate amount per round (1..`DATA_W`-1).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 2: command. 2'b01 = begin message; 2'b11 = abort; 2'b00 and 2'b10 = no-op.
- `data` in `DATA_W`: message word.
- `data_valid` in 1: `data` is valid.
- `data_last` in 1: qualifies the final word of the message; sampled with `data_valid`.
- `data_ready` out 1: engine accepts a word this cycle.
- `finished` out 3: status. 3'b000 = idle since reset; 3'b001 = busy; 3'b010 = done, `hash` valid; 3'b100 = aborted.
- `hash` out `DATA_W`: message digest.

## Operation

- **States:** IDLE, LOAD, COMP, FINAL, DONE.
- **Reset:** state IDLE, `finished`=000, `hash`=0, `data_ready`=0, accumulator=IV, buffer, counters and last flag cleared.
- **IDLE/DONE/aborted, start==01:**
  - acc←IV, word count←0, buffer cleared, `hash`←0, `finished`←001.
  - Go to LOAD.
- **LOAD:**
  - `data_ready`=1, driven combinationally from state.
  - On `data_valid`&`data_ready`: buf[wptr]←`data`, wptr++, total count++ (wraps mod 2^`DATA_W`), last flag←`data_last`.
  - Go to COMP when wptr reaches `BLOCK_WORDS` or when `data_last` is accepted.
  - Unfilled buffer slots stay zero (zero padding).
- **COMP:**
  - `BLOCK_WORDS` cycles, idx 0..`BLOCK_WORDS`-1. r = rotl(acc, `ROT`), w = buf[idx].
  - Per idx mod 4: 0: acc←r+w; 1: acc←r^w; 2: acc←r−w; 3: acc←r^~w. All arithmetic mod 2^`DATA_W`.
  - After the last idx: buffer and wptr cleared. If the last flag is set, go to FINAL; otherwise go to LOAD.
- **FINAL:** `hash`←acc ^ total count, `finished`←010, go to DONE.
- **DONE:** `hash` and `finished` hold until the next accepted start.
- **Abort (start==11) in LOAD/COMP/FINAL:**
  - Go to IDLE, `finished`←100, `hash`←0.
  - A word presented in the same cycle is dropped.
  - Abort in IDLE/DONE is ignored.
- **start==01 in LOAD/COMP/FINAL:** ignored; the message in progress continues.
- **Edge cases:**
  - A message that ends exactly on a block boundary gets no extra padding block.
  - `data_last` on the first word yields a single block of one word plus zeros.
  - Empty messages are not representable.

## Timing

- **Start:** accepted on edge E; `finished`=001 and `data_ready`=1 from E.
- **Throughput:** in LOAD, one word per cycle; `data_ready` drops for `BLOCK_WORDS` cycles per block during COMP.
- **Latency:** last word accepted on edge L → `finished`=010 and `hash` valid after edge L+`BLOCK_WORDS`+1.
- **Abort:** registered; `data_ready`=0 and `finished`=100 after the abort edge.
- **Async reset:** an assertion mid-operation forces the reset values immediately, independent of `clk`.

## Test plan

- **Reset:** assert `reset`=0 mid-LOAD → `finished`=000, `hash`=0, `data_ready`=0 without a clock edge; after release the engine stays IDLE.
- **Single word:** defaults; start=01, then one word 32'h0 with `data_last` → exactly 5 cycles after acceptance `finished`=010, `hash`=32'hA98F_EDCA.
- **Multi-block:** 9 words with continuous `data_valid` → `data_ready` low 4 cycles after words 4 and 8; third block zero-padded; `hash` matches reference model, including count 9.
- **Backpressure/gaps:** random `data_valid` gaps across a 6-word message → same `hash` as the gap-free run; `data_ready` never high in COMP.
- **Abort:** start=11 on the cycle word 3 is presented → `finished`=100, word dropped; restart with start=01 and the 1-word message → `hash`=32'hA98F_EDCA.
- **Ignored commands:** start=01 and start=10 during COMP → no effect on result or cycle count; start=11 in DONE → `finished` stays 010, `hash` held.

Source files
------------

// File: rtl/block_hash_if.sv
// Message-stream and status bundle for the block hash engine.
// The master drives the command and message words; the slave returns ready, status and digest.
interface block_hash_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        start;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;
  logic [2:0]        finished;
  logic [DATA_W-1:0] hash;

  modport master (
    output start, data, data_valid, data_last,
    input  data_ready, finished, hash
  );

  modport slave (
    input  start, data, data_valid, data_last,
    output data_ready, finished, hash
  );
endinterface

// File: rtl/block_hash.sv
// Multi-word hash engine: buffers words into blocks, compresses each block into a
// rotating accumulator with an add/xor/sub/xnor round schedule, then folds in the length.
//
// state   | meaning
// S_IDLE  | after reset or abort; waits for begin command
// S_LOAD  | accepting message words into the block buffer
// S_COMP  | one round per buffered word, BLOCK_WORDS cycles
// S_FINAL | digest = accumulator ^ word count
// S_DONE  | digest and status held until the next begin command
module block_hash #(
  parameter int          DATA_W      = 32,
  parameter int          BLOCK_WORDS = 4,
  parameter logic [31:0] IV          = 32'h0123_4567,
  parameter int          ROT         = 5
) (
  input logic         clk,
  input logic         reset,
  block_hash_if.slave bus
);
  localparam int                IDX_W     = $clog2(BLOCK_WORDS);
  localparam logic [DATA_W-1:0] IV_W      = DATA_W'(IV);
  localparam logic [2:0]        FIN_IDLE  = 3'b000;
  localparam logic [2:0]        FIN_BUSY  = 3'b001;
  localparam logic [2:0]        FIN_DONE  = 3'b010;
  localparam logic [2:0]        FIN_ABORT = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_FINAL, S_DONE} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] acc, acc_n, total, hash_q, rot, w;
  logic [DATA_W-1:0] blk_buf [BLOCK_WORDS];
  logic [IDX_W-1:0]  wptr, idx;
  logic              last_q;
  logic [2:0]        fin_q;
  logic              start_cmd, abort_cmd, busy, accept, blk_end;

  assign bus.data_ready = (state == S_LOAD);
  assign bus.finished   = fin_q;
  assign bus.hash       = hash_q;

  always_comb begin
    start_cmd = (bus.start == 2'b01);
    abort_cmd = (bus.start == 2'b11);
    busy      = (state == S_LOAD) || (state == S_COMP) || (state == S_FINAL);
    accept    = (state == S_LOAD) && bus.data_valid && !abort_cmd;
    blk_end   = (idx == IDX_W'(BLOCK_WORDS - 1));
    rot       = (acc << ROT) | (acc >> (DATA_W - ROT));
    w         = blk_buf[idx];
    case (2'(idx))
      2'd0:    acc_n = rot + w;
      2'd1:    acc_n = rot ^ w;
      2'd2:    acc_n = rot - w;
      default: acc_n = rot ^ ~w;
    endcase
  end

  always_comb begin
    state_n = state;
    if (busy && abort_cmd) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start_cmd) state_n = S_LOAD;
        S_LOAD: if (accept && (bus.data_last || wptr == IDX_W'(BLOCK_WORDS - 1))) state_n = S_COMP;
        S_COMP: if (blk_end) state_n = last_q ? S_FINAL : S_LOAD;
        S_FINAL: state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= IV_W;
      total  <= '0;
      hash_q <= '0;
      fin_q  <= FIN_IDLE;
      wptr   <= '0;
      idx    <= '0;
      last_q <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) blk_buf[i] <= '0;
    end else if (busy && abort_cmd) begin
      fin_q  <= FIN_ABORT;
      hash_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_cmd) begin
            acc    <= IV_W;
            total  <= '0;
            hash_q <= '0;
            fin_q  <= FIN_BUSY;
            wptr   <= '0;
            idx    <= '0;
            last_q <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) blk_buf[i] <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            blk_buf[wptr] <= bus.data;
            wptr          <= wptr + IDX_W'(1);
            total         <= total + DATA_W'(1);
            last_q        <= bus.data_last;
          end
        end
        S_COMP: begin
          acc <= acc_n;
          idx <= idx + IDX_W'(1);
          // zero padding for a short final block relies on this clear
          if (blk_end) begin
            wptr <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) blk_buf[i] <= '0;
          end
        end
        S_FINAL: begin
          hash_q <= acc ^ total;
          fin_q  <= FIN_DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_block_hash.sv
// Directed bench for block_hash: single word, multi-block, gaps, abort,
// ignored commands and asynchronous reset, with a small spec-level digest model.
module tb_block_hash;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  logic [31:0] msg [0:15];
  logic [31:0] exp6, exp9;

  block_hash_if #(.DATA_W(32)) bus ();

  block_hash #(
    .DATA_W(32), .BLOCK_WORDS(4), .IV(32'h0123_4567), .ROT(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // digest straight from the algorithm description: zero-padded 4-word blocks
  function automatic logic [31:0] model(input int n);
    logic [31:0] acc = 32'h0123_4567;
    logic [31:0] r, ww;
    int nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 4; i++) begin
        ww = (b * 4 + i < n) ? msg[b * 4 + i] : 32'h0;
        r  = (acc << 5) | (acc >> 27);
        case (i)
          0: acc = r + ww;
          1: acc = r ^ ww;
          2: acc = r - ww;
          default: acc = ~(r ^ ww);
        endcase
      end
    end
    return acc ^ 32'(n);
  endfunction

  task automatic do_start();
    @(negedge clk);
    bus.start = 2'b01;
    @(negedge clk);
    bus.start = 2'b00;
    chk("start_finished", {29'b0, bus.finished}, 32'h1);
    chk("start_ready", {31'b0, bus.data_ready}, 32'h1);
  endtask

  // streams msg[0..n-1]; checks ready is low for the 4 COMP cycles after each block
  task automatic feed(input int n, input bit gaps, input bit cmds, output int latency);
    int sent = 0;
    int comp_left = 0;
    int guard = 0;
    bit after_comp = 0;
    bit v, rdy;
    while (sent < n && guard < 400) begin
      @(negedge clk);
      guard++;
      bus.start = 2'b00;
      if (comp_left > 0) begin
        chk("ready_low_in_comp", {31'b0, bus.data_ready}, 32'h0);
        if (cmds) bus.start = (comp_left == 3) ? 2'b01 : (comp_left == 2) ? 2'b10 : 2'b00;
        comp_left--;
      end else if (after_comp) begin
        chk("ready_back_after_comp", {31'b0, bus.data_ready}, 32'h1);
        after_comp = 0;
      end
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.data_valid = v;
      bus.data       = msg[sent];
      bus.data_last  = (sent == n - 1);
      rdy = bus.data_ready;
      @(posedge clk);
      if (v && rdy) begin
        sent++;
        if (sent % 4 == 0 || sent == n) begin
          comp_left  = 4;
          after_comp = (sent != n);
        end
      end
    end
    if (sent != n) chk("feed_timeout", sent, n);
    latency = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.start      = 2'b00;
      bus.data_valid = 1'b0;
      bus.data_last  = 1'b0;
      if (bus.finished == 3'b010) break;
      latency++;
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.start      = 2'b00;
    bus.data       = '0;
    bus.data_valid = 1'b0;
    bus.data_last  = 1'b0;
    #23;
    chk("reset_finished", {29'b0, bus.finished}, 32'h0);
    chk("reset_hash", bus.hash, 32'h0);
    chk("reset_ready", {31'b0, bus.data_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // single zero word
    msg[0] = 32'h0;
    do_start();
    feed(1, 0, 0, lat);
    chk("single_hash", bus.hash, 32'hA98F_EDCA);
    chk("single_finished", {29'b0, bus.finished}, 32'h2);
    chk("single_latency", lat, 5);

    // nine words, third block padded
    for (int i = 0; i < 9; i++) msg[i] = (32'h9E37_79B9 * (i + 1)) ^ (32'h0F0F_0000 >> i);
    exp9 = model(9);
    do_start();
    feed(9, 0, 0, lat);
    chk("multi_hash", bus.hash, exp9);
    chk("multi_latency", lat, 5);

    // six words, gap-free then with random gaps
    for (int i = 0; i < 6; i++) msg[i] = 32'hC001_D00D + 32'h1111_0203 * i;
    exp6 = model(6);
    do_start();
    feed(6, 0, 0, lat);
    chk("six_hash", bus.hash, exp6);
    do_start();
    feed(6, 1, 0, lat);
    chk("gaps_hash", bus.hash, exp6);
    chk("gaps_latency", lat, 5);

    // begin / no-op commands while compressing
    do_start();
    feed(6, 0, 1, lat);
    chk("cmd_in_comp_hash", bus.hash, exp6);
    chk("cmd_in_comp_latency", lat, 5);

    // abort in DONE is ignored
    @(negedge clk);
    bus.start = 2'b11;
    @(negedge clk);
    bus.start = 2'b00;
    chk("abort_done_finished", {29'b0, bus.finished}, 32'h2);
    chk("abort_done_hash", bus.hash, exp6);

    // abort on the cycle the third word is offered
    do_start();
    for (int i = 0; i < 2; i++) begin
      bus.data_valid = 1'b1;
      bus.data       = msg[i];
      @(negedge clk);
    end
    bus.data  = msg[2];
    bus.start = 2'b11;
    @(negedge clk);
    bus.start      = 2'b00;
    bus.data_valid = 1'b0;
    chk("abort_finished", {29'b0, bus.finished}, 32'h4);
    chk("abort_ready", {31'b0, bus.data_ready}, 32'h0);
    chk("abort_hash", bus.hash, 32'h0);
    msg[0] = 32'h0;
    do_start();
    feed(1, 0, 0, lat);
    chk("restart_hash", bus.hash, 32'hA98F_EDCA);
    chk("restart_latency", lat, 5);

    // asynchronous reset mid-LOAD
    msg[0] = 32'h1234_5678;
    msg[1] = 32'h9ABC_DEF0;
    do_start();
    for (int i = 0; i < 2; i++) begin
      bus.data_valid = 1'b1;
      bus.data       = msg[i];
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_finished", {29'b0, bus.finished}, 32'h0);
    chk("async_hash", bus.hash, 32'h0);
    chk("async_ready", {31'b0, bus.data_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_finished", {29'b0, bus.finished}, 32'h0);
    chk("post_reset_ready", {31'b0, bus.data_ready}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
